// File: rtl/pio_fault_pkg.sv
// rtl/pio_fault_pkg.sv - shared constants for the fault capture block
// Purpose: edge-selection encoding and register offsets used by
// pio_debounce and pio_fault_capture. No ports.
package pio_fault_pkg;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

    localparam logic [1:0] REG_DATA        = 2'd0;
    localparam logic [1:0] REG_RESERVED    = 2'd1;
    localparam logic [1:0] REG_IRQMASK     = 2'd2;
    localparam logic [1:0] REG_EDGECAPTURE = 2'd3;

endpackage

// File: rtl/pio_debounce.sv
// rtl/pio_debounce.sv - one channel: synchroniser, debounce counter, stable level
// Purpose: bring one asynchronous fault input into the clk domain, accept a
// level change only after it has been stable long enough, and flag the edge.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   in_bit     : asynchronous input
//   stable     : debounced level
//   rise, fall : high in the cycle whose closing edge changes stable 0->1 / 1->0
module pio_debounce
    import pio_fault_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic stable,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_val;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // The last synchroniser flop is the stable value; its edge is
            // predicted from the stage feeding it so the pulse lines up with
            // the clock edge that changes stable.
            assign stable = sync_val;
            assign rise   = sync_q[SYNC_STAGES-2] & ~sync_val;
            assign fall   = ~sync_q[SYNC_STAGES-2] & sync_val;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_q;
            logic             stable_d;
            logic             accept;

            // The counter clears on acceptance, so it tops out at CNT_LAST
            // and never wraps.
            always_comb begin
                accept   = (sync_val != stable_q) && (cnt_q == CNT_LAST);
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (sync_val == stable_q) begin
                    cnt_d = '0;
                end else if (accept) begin
                    stable_d = sync_val;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable = stable_q;
            assign rise   = accept & sync_val;
            assign fall   = accept & ~sync_val;
        end
    endgenerate

endmodule

// File: rtl/pio_fault_capture.sv
// rtl/pio_fault_capture.sv - debounced fault inputs with edge capture and irq
// Purpose: WIDTH debounced fault channels behind a four-register slave port
// (data, reserved, irqmask, edgecapture) with a level interrupt.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   address, chipselect : register offset and slave select
//   write_n, writedata  : active-low write strobe and write data
//   in_port             : asynchronous fault inputs
//   readdata            : registered read data, one clock latency
//   irq                 : OR of edgecapture & irqmask
module pio_fault_capture
    import pio_fault_pkg::*;
#(
    parameter int         WIDTH           = 4,
    parameter int         SYNC_STAGES     = 2,
    parameter int         DEBOUNCE_CYCLES = 3,
    parameter edge_type_e EDGE_TYPE       = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] clear;
    logic             wr_en;

    logic [WIDTH-1:0] readdata_q;
    logic [WIDTH-1:0] readdata_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecapture_q;
    logic [WIDTH-1:0] edgecapture_d;

    genvar ch;
    generate
        for (ch = 0; ch < WIDTH; ch++) begin : g_chan
            pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .in_bit (in_port[ch]),
                .stable (stable[ch]),
                .rise   (rise[ch]),
                .fall   (fall[ch])
            );
        end
    endgenerate

    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISING:  capture = rise;
            EDGE_FALLING: capture = fall;
            default:      capture = rise | fall;
        endcase
    end

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        clear     = '0;
        irqmask_d = irqmask_q;
        if (wr_en && (address == REG_EDGECAPTURE)) begin
            clear = writedata;
        end
        if (wr_en && (address == REG_IRQMASK)) begin
            irqmask_d = writedata;
        end
        // OR-ing the new edges after the clear makes a coincident set win.
        edgecapture_d = (edgecapture_q & ~clear) | capture;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            REG_DATA:        readdata_d = stable;
            REG_RESERVED:    readdata_d = '0;
            REG_IRQMASK:     readdata_d = irqmask_q;
            REG_EDGECAPTURE: readdata_d = edgecapture_q;
            default:         readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q    <= '0;
            irqmask_q     <= '0;
            edgecapture_q <= '0;
        end else begin
            readdata_q    <= readdata_d;
            irqmask_q     <= irqmask_d;
            edgecapture_q <= edgecapture_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecapture_q & irqmask_q);

endmodule

// File: tb/tb_pio_fault_capture.sv
// tb/tb_pio_fault_capture.sv - self-checking bench for pio_fault_capture
module tb_pio_fault_capture;
    import pio_fault_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [3:0] writedata;
    logic [3:0] in_port;
    logic [3:0] readdata;
    logic       irq;

    int checks = 0;
    int fails  = 0;

    logic [3:0] sb[$];
    logic [3:0] got;
    logic [3:0] exp_v;

    always #5 clk = ~clk;

    pio_fault_capture #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (3),
        .EDGE_TYPE       (EDGE_RISING)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [3:0] d);
        address = a;
        tick(1);
        d = readdata;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [3:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        checks++;
        if (readdata !== 4'h0 || irq !== 1'b0) begin
            $display("FAIL reset_out readdata=%h irq=%b expected 0/0", readdata, irq);
            fails++;
        end
        for (int a = 0; a < 4; a++) begin
            sb.push_back(4'h0);
            read_reg(2'(a), got);
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                $display("FAIL reset_read off%0d got=%h expected=%h", a, got, exp_v);
                fails++;
            end
        end
    endtask

    task automatic test_rise_latency();
        address = REG_DATA;
        in_port = 4'h5;
        sb.push_back(4'h0);
        sb.push_back(4'h5);
        sb.push_back(4'h5);
        tick(5);
        exp_v = sb.pop_front();
        checks++;
        if (readdata !== exp_v) begin
            $display("FAIL latency_early got=%h expected=%h", readdata, exp_v);
            fails++;
        end
        tick(1);
        exp_v = sb.pop_front();
        checks++;
        if (readdata !== exp_v) begin
            $display("FAIL latency_data got=%h expected=%h", readdata, exp_v);
            fails++;
        end
        read_reg(REG_EDGECAPTURE, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v || irq !== 1'b0) begin
            $display("FAIL latency_edge got=%h irq=%b expected=%h irq=0", got, irq, exp_v);
            fails++;
        end
    endtask

    task automatic test_glitch();
        in_port = 4'h7;
        tick(2);
        in_port = 4'h5;
        tick(8);
        sb.push_back(4'h5);
        sb.push_back(4'h5);
        read_reg(REG_DATA, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            $display("FAIL glitch_data got=%h expected=%h", got, exp_v);
            fails++;
        end
        read_reg(REG_EDGECAPTURE, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            $display("FAIL glitch_edge got=%h expected=%h", got, exp_v);
            fails++;
        end
        in_port = 4'h0;
        tick(8);
        write_reg(REG_EDGECAPTURE, 4'hF);
        sb.push_back(4'h0);
        sb.push_back(4'h0);
        read_reg(REG_EDGECAPTURE, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            $display("FAIL fall_noedge got=%h expected=%h", got, exp_v);
            fails++;
        end
        read_reg(REG_DATA, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            $display("FAIL fall_data got=%h expected=%h", got, exp_v);
            fails++;
        end
    endtask

    task automatic test_reg_map();
        write_reg(REG_RESERVED, 4'hF);
        write_reg(REG_DATA, 4'hF);
        write_reg(REG_IRQMASK, 4'hA);
        sb.push_back(4'h0);
        sb.push_back(4'h0);
        sb.push_back(4'hA);
        read_reg(REG_RESERVED, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            $display("FAIL reserved got=%h expected=%h", got, exp_v);
            fails++;
        end
        read_reg(REG_DATA, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            $display("FAIL data_ro got=%h expected=%h", got, exp_v);
            fails++;
        end
        read_reg(REG_IRQMASK, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            $display("FAIL irqmask_rw got=%h expected=%h", got, exp_v);
            fails++;
        end
    endtask

    task automatic test_irq_clear();
        write_reg(REG_IRQMASK, 4'h1);
        address = REG_EDGECAPTURE;
        in_port = 4'h1;
        tick(4);
        checks++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_early got=%b expected=0", irq);
            fails++;
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            $display("FAIL irq_set got=%b expected=1", irq);
            fails++;
        end
        write_reg(REG_EDGECAPTURE, 4'h1);
        checks++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_clear got=%b expected=0", irq);
            fails++;
        end
        sb.push_back(4'h0);
        read_reg(REG_EDGECAPTURE, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            $display("FAIL w1c_edge got=%h expected=%h", got, exp_v);
            fails++;
        end
    endtask

    task automatic test_set_wins();
        in_port = 4'h0;
        tick(8);
        in_port = 4'h1;
        tick(4);
        write_reg(REG_EDGECAPTURE, 4'h1);
        checks++;
        if (irq !== 1'b1) begin
            $display("FAIL setwins_irq got=%b expected=1", irq);
            fails++;
        end
        sb.push_back(4'h1);
        read_reg(REG_EDGECAPTURE, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            $display("FAIL setwins_edge got=%h expected=%h", got, exp_v);
            fails++;
        end
        in_port = 4'h0;
        tick(8);
        write_reg(REG_EDGECAPTURE, 4'hF);
        write_reg(REG_IRQMASK, 4'h0);
    endtask

    task automatic test_reset_mid_debounce();
        address = REG_DATA;
        in_port = 4'h4;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (readdata !== 4'h0 || irq !== 1'b0) begin
            $display("FAIL midrst_out readdata=%h irq=%b expected 0/0", readdata, irq);
            fails++;
        end
        sb.push_back(4'h0);
        sb.push_back(4'h4);
        sb.push_back(4'h4);
        tick(5);
        exp_v = sb.pop_front();
        checks++;
        if (readdata !== exp_v) begin
            $display("FAIL midrst_early got=%h expected=%h", readdata, exp_v);
            fails++;
        end
        tick(1);
        exp_v = sb.pop_front();
        checks++;
        if (readdata !== exp_v) begin
            $display("FAIL midrst_data got=%h expected=%h", readdata, exp_v);
            fails++;
        end
        read_reg(REG_EDGECAPTURE, got);
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v || irq !== 1'b0) begin
            $display("FAIL midrst_edge got=%h irq=%b expected=%h irq=0", got, irq, exp_v);
            fails++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 4'h0;
        in_port    = 4'h0;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_reg_map();
        test_irq_clear();
        test_set_wins();
        test_reset_mid_debounce();
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_left got=%0d expected=0", sb.size());
            fails++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
